// File: rtl/alu_pipe.sv
// Two-stage pipelined Hack-style ALU: operand preprocessing in S1, add/and, output
// inversion and flag generation in S2, with a valid/ready handshake on both sides.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [5:0]       in_ctl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags
);

  localparam int MSB = WIDTH - 1;

  // Stage 1 state: preprocessed operands plus the control bits still needed.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic             s1_f;
  logic             s1_no;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2 state: final result, drives the out_* ports directly.
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic [3:0]       s2_flags;
  logic [TAG_W-1:0] s2_tag;

  logic s2_adv;
  logic s1_adv;

  // A stage may take new data when it is empty or its content moves on this cycle.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Zero is applied before negate on each operand.
  logic [WIDTH-1:0] pre_x;
  logic [WIDTH-1:0] pre_y;

  always_comb begin
    // NOTE: every variable gets a value before any condition so no latch is inferred.
    pre_x = in_ctl[5] ? '0 : in_x;
    pre_y = in_ctl[3] ? '0 : in_y;
    if (in_ctl[4]) pre_x = ~pre_x;
    if (in_ctl[2]) pre_y = ~pre_y;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: datapath registers are cleared too, so out_* reads as zero after reset.
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_f     <= 1'b0;
      s1_no    <= 1'b0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x   <= pre_x;
        s1_y   <= pre_y;
        s1_f   <= in_ctl[1];
        s1_no  <= in_ctl[0];
        s1_tag <= in_tag;
      end
    end
  end

  // One extra bit on the adder captures the carry-out.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] core;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;

  always_comb begin
    sum    = {1'b0, s1_x} + {1'b0, s1_y};
    core   = s1_f ? sum[MSB:0] : (s1_x & s1_y);
    result = s1_no ? ~core : core;
    carry  = s1_f && sum[WIDTH];
    // Signed overflow: operands share a sign that the sum does not.
    ovf    = s1_f && (s1_x[MSB] == s1_y[MSB]) && (sum[MSB] != s1_x[MSB]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_flags <= '0;
      s2_tag   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data  <= result;
        s2_flags <= {(result == '0), result[MSB], carry, ovf};
        s2_tag   <= s1_tag;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;
  assign out_flags = s2_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors with literal expectations plus an
// arithmetic reference model and in-order scoreboard checked on every falling edge.
module tb_alu_pipe;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic [5:0]       in_ctl = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_ctl(in_ctl), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference model in plain integer arithmetic: returns {data, flags}.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [5:0] ctl);
    logic [15:0] x2, y2, r;
    int unsigned usum;
    int          ssum;
    logic        cy, ov;
    x2 = ctl[5] ? 16'h0 : x;
    if (ctl[4]) x2 = ~x2;
    y2 = ctl[3] ? 16'h0 : y;
    if (ctl[2]) y2 = ~y2;
    usum = int'(x2) + int'(y2);
    ssum = int'($signed(x2)) + int'($signed(y2));
    if (ctl[1]) begin
      r  = 16'(usum);
      cy = usum > 65535;
      ov = (ssum > 32767) || (ssum < -32768);
    end else begin
      r  = x2 & y2;
      cy = 1'b0;
      ov = 1'b0;
    end
    if (ctl[0]) r = ~r;
    return {r, (r == 16'h0), r[15], cy, ov};
  endfunction

  // Scoreboard and stall-stability monitor.
  logic             held_valid = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic [TAG_W-1:0] held_tag;
  logic [3:0]       held_flags;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_valid = 1'b0;
    end else begin
      if (held_valid && out_valid) begin
        check("stall_data",  out_data,  held_data);
        check("stall_tag",   out_tag,   held_tag);
        check("stall_flags", out_flags, held_flags);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_data",  out_data,  e.data);
          check("sb_flags", out_flags, e.flags);
          check("sb_tag",   out_tag,   e.tag);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        logic [19:0] m;
        m = model(in_x, in_y, in_ctl);
        e.data  = m[19:4];
        e.flags = m[3:0];
        e.tag   = in_tag;
        exp_q.push_back(e);
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      held_tag   = out_tag;
      held_flags = out_flags;
    end
  end

  // Presents one op from posedge+1 and returns posedge+1 after the accepting edge.
  task automatic send_op(input logic [15:0] x, input logic [15:0] y,
                         input logic [5:0] ctl, input logic [TAG_W-1:0] tag);
    bit ok = 1'b0;
    in_x = x; in_y = y; in_ctl = ctl; in_tag = tag; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    if (!ok) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Single op into an empty pipe with literal expected result and 2-cycle latency.
  task automatic lit_op(input string name, input logic [15:0] x, input logic [15:0] y,
                        input logic [5:0] ctl, input logic [TAG_W-1:0] tag,
                        input logic [15:0] exp_data, input logic [3:0] exp_flags);
    out_ready = 1'b1;
    send_op(x, y, ctl, tag);
    @(negedge clk);
    check({name, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_data"},  out_data,  exp_data);
    check({name, "_flags"}, out_flags, exp_flags);
    check({name, "_tag"},   out_tag,   tag);
    @(posedge clk); #1;
  endtask

  logic [5:0] ctl_tab [13] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                               6'b001101, 6'b001111, 6'b011111, 6'b000010, 6'b010011,
                               6'b000111, 6'b000000, 6'b010101};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] m;

    // Pin the model against hand-computed values.
    m = model(16'h0005, 16'h0003, 6'b000010);
    check("model_add", m, {16'h0008, 4'b0000});
    m = model(16'h0003, 16'h0005, 6'b010011);
    check("model_sub", m, {16'hFFFE, 4'b0110});
    m = model(16'h7FFF, 16'h0001, 6'b000010);
    check("model_ovf", m, {16'h8000, 4'b0101});
    m = model(16'h00F0, 16'h0F3C, 6'b000000);
    check("model_and", m, {16'h0030, 4'b0000});

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  16'h0);
    check("rst_out_tag",   out_tag,   4'h0);
    check("rst_out_flags", out_flags, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed single operations.
    lit_op("add",    16'h0005, 16'h0003, 6'b000010, 4'h1, 16'h0008, 4'b0000);
    lit_op("sub",    16'h0003, 16'h0005, 6'b010011, 4'h2, 16'hFFFE, 4'b0110);
    lit_op("carry",  16'hFFFF, 16'h0001, 6'b000010, 4'h3, 16'h0000, 4'b1010);
    lit_op("ovf",    16'h7FFF, 16'h0001, 6'b000010, 4'h4, 16'h8000, 4'b0101);
    lit_op("zero",   16'h1234, 16'hABCD, 6'b101010, 4'h5, 16'h0000, 4'b1000);
    lit_op("and_no", 16'h00F0, 16'h0F3C, 6'b000001, 4'h6, 16'hFFCF, 4'b0100);

    // Backpressure: two ops fill the pipe, the third waits.
    out_ready = 1'b0;
    in_x = 16'h0001; in_y = 16'h0002; in_ctl = 6'b000010; in_tag = 4'h1; in_valid = 1'b1;
    @(negedge clk);
    check("bp_ready1", in_ready, 1'b1);
    @(posedge clk); #1;
    in_x = 16'h0010; in_y = 16'h0020; in_tag = 4'h2;
    @(negedge clk);
    check("bp_ready2", in_ready, 1'b1);
    @(posedge clk); #1;
    in_x = 16'h0100; in_y = 16'h0200; in_tag = 4'h3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_full_ready", in_ready,  1'b0);
      check("bp_full_valid", out_valid, 1'b1);
      check("bp_full_tag",   out_tag,   4'h1);
      check("bp_full_data",  out_data,  16'h0003);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_tag1",          out_tag,  4'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid2", out_valid, 1'b1);
    check("bp_tag2",   out_tag,   4'h2);
    @(negedge clk);
    check("bp_valid3", out_valid, 1'b1);
    check("bp_tag3",   out_tag,   4'h3);
    check("bp_data3",  out_data,  16'h0300);
    @(negedge clk);
    check("bp_drained", out_valid, 1'b0);
    @(posedge clk); #1;

    // Full-rate stream with intermittent backpressure, checked by the scoreboard.
    for (int i = 0; i < 26; i++) begin
      out_ready = (i % 4) != 3;
      send_op(16'(i * 16'h3A7D + 16'h0101), 16'(i * 16'h1C3B ^ 16'hF00F),
              ctl_tab[i % 13], 4'(i));
    end
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Reset with a full pipe discards everything in flight.
    out_ready = 1'b0;
    send_op(16'h0011, 16'h0022, 6'b000010, 4'h5);
    send_op(16'h0033, 16'h0044, 6'b000010, 4'h6);
    @(negedge clk);
    check("pre_rst_full", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid",    out_valid, 1'b0);
    check("post_rst_in_ready", in_ready,  1'b1);
    check("post_rst_tag",      out_tag,   4'h0);
    check("post_rst_data",     out_data,  16'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
